bist_scheduler: RTL and testbench
=================================

// Module: bist_scheduler
// PURPOSE
//  Sequences up to N_ENG BIST controller instances one at a time from a single start pulse.
//  Per engine: launch with a 1-cycle start pulse, wait for its bist_end pulse or a timeout, record pass/fail.
//  Sits between the top-level test-mode logic and the per-block BIST controllers.
//  Only one engine runs at a time.
// PARAMETERS
//  N_ENG      4    number of BIST engines scheduled (1..16)
//  TIMEOUT    200  max cycles in WAIT per engine before timeout is declared (>=2)
//  TMO_W      8    timeout counter width; must satisfy 2**TMO_W > TIMEOUT
// PORTS
//  clk        in   1      clock, rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  start      in   1      begin a session; sampled in IDLE only
//  abort      in   1      terminate session; sampled in any state
//  eng_mask   in   N_ENG  1 = schedule engine i; latched at start
//  eng_done   in   N_ENG  per-engine bist_end pulse
//  eng_pass   in   N_ENG  per-engine pass flag, valid with eng_done[i]
//  eng_start  out  N_ENG  1-cycle launch pulse, one-hot or zero
//  busy       out  1      high in every state except IDLE
//  sess_done  out  1      1-cycle pulse at session end, normal or aborted
//  aborted    out  1      set when session ended by abort; cleared at next start
//  pass_map   out  N_ENG  bit i = engine i passed
//  tmo_map    out  N_ENG  bit i = engine i timed out
//  retry_map  out  N_ENG  bit i = engine i was retried (0 without the retry feature)
// BEHAVIOUR
//  Reset (reset_n=0, any time, async): state=IDLE, idx=0, timer=0; all outputs 0. Takes effect mid-session immediately.
//  States: IDLE, SCAN, LAUNCH, WAIT, NEXT, REPORT; all registered.
//  IDLE:
//   - start=1 & abort=0: mask_q<=eng_mask; clear pass/tmo/retry_map and aborted; idx<=0; ->SCAN.
//   - start is ignored in all other states.
//  SCAN: mask_q[idx]=1 ->LAUNCH; else ->NEXT. Costs 1 cycle per index, skipped or not.
//  LAUNCH: eng_start[idx]=1 for this cycle only; timer<=TIMEOUT; ->WAIT.
//  WAIT (only eng_done[idx] observed; other bits ignored):
//   - eng_done[idx]=1: pass_map[idx]<=eng_pass[idx]; ->NEXT.
//   - else: timer decrements each cycle. At timer==1 with no done: tmo_map[idx]<=1, pass_map[idx]<=0; ->NEXT.
//   - done in the same cycle as expiry: done wins, no timeout recorded.
//  NEXT: idx==N_ENG-1 ->REPORT; else idx<=idx+1, ->SCAN.
//  REPORT: sess_done=1 for one cycle; ->IDLE. Maps hold until next accepted start.
//  Latency: start sampled at edge k, mask[0]=1 -> eng_start[0] high in cycle k+2.
//   - Mask all-zero: sess_done in cycle k+1+2*N_ENG, all maps 0.
//  Abort (any non-IDLE state): next state IDLE; sess_done pulses that cycle; aborted<=1.
//   - eng_start is forced to 0 in the abort cycle.
//   - Already-recorded map bits are kept; the current engine is not recorded.
//  Abort in IDLE: ignored; start+abort together in IDLE: no session begins.
//  idx width = clog2(N_ENG), min 1. Engine index is never written outside 0..N_ENG-1.
// CONFIGURATION
//  BIST_SCHED_RETRY_EN defined: a fail (done with pass=0) or a timeout on the first attempt:
//   - sets retry_map[idx]; ->LAUNCH again for the same idx; tmo/pass bits are rewritten by the 2nd attempt.
//   - A 2nd failure is final.
//  BIST_SCHED_RETRY_EN undefined: no retry; retry_map tied to 0; port list unchanged.
// TESTING (bench: N_ENG=4, TIMEOUT=20, engines modelled as done+pass after fixed delays)
//  1. mask=4'b1111, all pass after 5 cycles -> eng_start pulses 0,1,2,3 in order;
//     sess_done once; pass_map=4'b1111, tmo_map=0.
//  2. mask=4'b0101 -> only eng_start[0],[2] pulse; pass_map=4'b0101; engines 1,3 never started.
//  3. Engine 2 never responds -> tmo_map=4'b0100, pass_map=4'b1011.
//     WAIT for engine 2 lasts exactly 20 cycles; session continues to engine 3.
//  4. abort 10 cycles after start; restart during busy ignored -> sess_done 1 cycle later, aborted=1, busy=0.
//     New start then clears aborted and maps.
//  5. reset_n low for 3ns mid-WAIT -> all outputs 0 asynchronously.
//     Following start runs a full session normally.
//  6. RETRY_EN: engine 1 fails first, passes second -> retry_map=4'b0010, pass_map=4'b1111,
//     eng_start[1] pulses twice. Without RETRY_EN: pass_map=4'b1101.

Source files
------------

// File: rtl/bist_scheduler.sv
// Sequences N_ENG BIST engines one at a time with per-engine timeout.
// Define BIST_SCHED_RETRY_EN to relaunch an engine once after a fail or timeout.
module bist_scheduler #(
  parameter int N_ENG   = 4,
  parameter int TIMEOUT = 200,
  parameter int TMO_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_ENG-1:0] eng_mask,
  input  logic [N_ENG-1:0] eng_done,
  input  logic [N_ENG-1:0] eng_pass,
  output logic [N_ENG-1:0] eng_start,
  output logic             busy,
  output logic             sess_done,
  output logic             aborted,
  output logic [N_ENG-1:0] pass_map,
  output logic [N_ENG-1:0] tmo_map,
  output logic [N_ENG-1:0] retry_map
);

  localparam int IW = (N_ENG > 1) ? $clog2(N_ENG) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_ENG - 1);

  typedef enum logic [2:0] {
    IDLE, SCAN, LAUNCH, WAIT, NEXT, REPORT
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic [N_ENG-1:0] mask_q, mask_d;
  logic [N_ENG-1:0] pass_q, pass_d;
  logic [N_ENG-1:0] tmo_q, tmo_d;
  logic [N_ENG-1:0] start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             abrt_q, abrt_d;

`ifdef BIST_SCHED_RETRY_EN
  logic [N_ENG-1:0] retry_q, retry_d;
  logic             tried_q, tried_d;
  logic             fail;

  // first-attempt outcome that triggers a relaunch
  assign fail = (state_q == WAIT) &&
                (eng_done[idx_q] ? !eng_pass[idx_q]
                                 : (timer_q == TMO_W'(1)));
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    abrt_d  = abrt_q;
    start_d = '0;
    done_d  = 1'b0;
`ifdef BIST_SCHED_RETRY_EN
    retry_d = retry_q;
    tried_d = tried_q;
`endif
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b1;
      abrt_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            mask_d  = eng_mask;
            pass_d  = '0;
            tmo_d   = '0;
            abrt_d  = 1'b0;
            idx_d   = '0;
            state_d = SCAN;
`ifdef BIST_SCHED_RETRY_EN
            retry_d = '0;
            tried_d = 1'b0;
`endif
          end
        end
        SCAN: state_d = mask_q[idx_q] ? LAUNCH : NEXT;
        LAUNCH: begin
          start_d[idx_q] = 1'b1;
          timer_d        = TMO_W'(TIMEOUT);
          state_d        = WAIT;
        end
        WAIT: begin
          if (eng_done[idx_q]) begin
            pass_d[idx_q] = eng_pass[idx_q];
            tmo_d[idx_q]  = 1'b0;
            state_d       = NEXT;
          end else if (timer_q == TMO_W'(1)) begin
            pass_d[idx_q] = 1'b0;
            tmo_d[idx_q]  = 1'b1;
            state_d       = NEXT;
          end else begin
            timer_d = timer_q - TMO_W'(1);
          end
`ifdef BIST_SCHED_RETRY_EN
          if (fail && !tried_q) begin
            retry_d[idx_q] = 1'b1;
            tried_d        = 1'b1;
            state_d        = LAUNCH;
          end
`endif
        end
        NEXT: begin
`ifdef BIST_SCHED_RETRY_EN
          tried_d = 1'b0;
`endif
          if (idx_q == LAST) begin
            state_d = REPORT;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = SCAN;
          end
        end
        REPORT: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      mask_q  <= '0;
      pass_q  <= '0;
      tmo_q   <= '0;
      start_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
`ifdef BIST_SCHED_RETRY_EN
      retry_q <= '0;
      tried_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
`ifdef BIST_SCHED_RETRY_EN
      retry_q <= retry_d;
      tried_q <= tried_d;
`endif
    end
  end

  assign eng_start = start_q;
  assign busy      = busy_q;
  assign sess_done = done_q;
  assign aborted   = abrt_q;
  assign pass_map  = pass_q;
  assign tmo_map   = tmo_q;
`ifdef BIST_SCHED_RETRY_EN
  assign retry_map = retry_q;
`else
  assign retry_map = '0;
`endif

endmodule

// File: tb/tb_bist_scheduler.sv
// Randomized bench for bist_scheduler against a session-timeline model.
// Engines answer a fixed number of WAIT cycles after their launch pulse.
module tb_bist_scheduler;

  localparam int TMO = 20;
`ifdef BIST_SCHED_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [3:0] eng_mask;
  logic [3:0] eng_done;
  logic [3:0] eng_pass;
  logic [3:0] eng_start;
  logic       busy;
  logic       sess_done;
  logic       aborted;
  logic [3:0] pass_map;
  logic [3:0] tmo_map;
  logic [3:0] retry_map;

  bist_scheduler #(
    .N_ENG  (4),
    .TIMEOUT(TMO),
    .TMO_W  (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .eng_mask (eng_mask),
    .eng_done (eng_done),
    .eng_pass (eng_pass),
    .eng_start(eng_start),
    .busy     (busy),
    .sess_done(sess_done),
    .aborted  (aborted),
    .pass_map (pass_map),
    .tmo_map  (tmo_map),
    .retry_map(retry_map)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // engine behaviour per attempt: delay in WAIT cycles (0 = silent)
  int   m_dly[4][2];
  bit   m_ps[4][2];

  int         e_cyc[$];
  int         e_idx[$];
  logic [3:0] e_pass, e_tmo, e_retry;
  bit         e_ab;
  int         e_end;

  task automatic set_all(input int d, input bit p);
    for (int i = 0; i < 4; i++)
      for (int a = 0; a < 2; a++) begin
        m_dly[i][a] = d;
        m_ps[i][a]  = p;
      end
  endtask

  // cycle 0 = first cycle after start is accepted; ab = abort cycle or -1
  task automatic model(input logic [3:0] mask, input int ab);
    int pos, w, d, a;
    bit stop, ok, more;
    e_cyc.delete();
    e_idx.delete();
    e_pass  = '0;
    e_tmo   = '0;
    e_retry = '0;
    stop    = 1'b0;
    pos     = 0;
    for (int i = 0; i < 4; i++) begin
      if (!stop) begin
        pos++;
        more = mask[i];
        a    = 0;
        while (more && !stop) begin
          if (ab >= 0 && pos >= ab) stop = 1'b1;
          else begin
            e_cyc.push_back(pos + 1);
            e_idx.push_back(i);
            d  = m_dly[i][a];
            ok = (d >= 1) && (d <= TMO);
            w  = ok ? d : TMO;
            if (ab >= 0 && pos + w >= ab) stop = 1'b1;
            else begin
              e_pass[i] = ok && m_ps[i][a];
              e_tmo[i]  = !ok;
              pos += w + 1;
              if (RETRY && a == 0 && !(ok && m_ps[i][a])) begin
                e_retry[i] = 1'b1;
                a = 1;
              end else more = 1'b0;
            end
          end
        end
        if (!stop) pos++;
      end
    end
    if (stop || (ab >= 0 && ab <= pos)) begin
      e_ab  = 1'b1;
      e_end = ab;
    end else begin
      e_ab  = 1'b0;
      e_end = pos;
    end
  endtask

  task automatic run(input logic [3:0] mask, input int ab,
                     input bit noise, input int rc);
    int resp[4];
    bit rps[4];
    int att[4];
    int g_cyc[$];
    int g_idx[$];
    int cur, sd_n, sd_c, bad_oh, d, n;
    bit halt;
    model(mask, ab);
    for (int i = 0; i < 4; i++) begin
      resp[i] = -1;
      att[i]  = 0;
      rps[i]  = 1'b0;
    end
    cur = -1; sd_n = 0; sd_c = -1; bad_oh = 0; halt = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    eng_mask = mask;
    for (int c = 0; c <= e_end + 3 && !halt; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (noise) eng_mask = 4'($urandom);
      if (eng_start != 4'b0) begin
        if (!$onehot(eng_start)) bad_oh++;
        for (int i = 0; i < 4; i++)
          if (eng_start[i]) begin
            g_cyc.push_back(c);
            g_idx.push_back(i);
            cur     = i;
            d       = m_dly[i][att[i] > 0 ? 1 : 0];
            rps[i]  = m_ps[i][att[i] > 0 ? 1 : 0];
            att[i]++;
            resp[i] = (d > 0) ? c + d - 1 : -1;
          end
      end
      if (sess_done) begin
        sd_n++;
        sd_c = c;
      end
      abort = (c == ab);
      for (int i = 0; i < 4; i++) begin
        eng_done[i] = (resp[i] == c) ||
                      (noise && i != cur && $urandom_range(0, 3) == 0);
        eng_pass[i] = (resp[i] == c) ? rps[i] : 1'($urandom);
      end
      if (noise && c <= e_end && $urandom_range(0, 3) == 0) start = 1'b1;
      if (c == rc) begin
        check("busy_pre_rst", 32'(busy), 32'd1);
        check("pass_pre_rst", 32'(pass_map), 32'h3);
        #1 reset_n = 1'b0;
        #1;
        check("rst_eng_start", 32'(eng_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sess_done", 32'(sess_done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_pass", 32'(pass_map), 32'd0);
        check("rst_tmo", 32'(tmo_map), 32'd0);
        check("rst_retry", 32'(retry_map), 32'd0);
        start = 1'b0; abort = 1'b0; eng_done = '0;
        #2 reset_n = 1'b1;
        halt = 1'b1;
      end
    end
    start = 1'b0; abort = 1'b0; eng_done = '0;
    if (!halt) begin
      check("sess_done_cnt", 32'(sd_n), 32'd1);
      check("sess_done_cyc", 32'(sd_c), 32'(e_end + 1));
      check("start_cnt", 32'(g_cyc.size()), 32'(e_cyc.size()));
      n = (g_cyc.size() < e_cyc.size()) ? g_cyc.size() : e_cyc.size();
      for (int k = 0; k < n; k++) begin
        check("start_cyc", 32'(g_cyc[k]), 32'(e_cyc[k]));
        check("start_idx", 32'(g_idx[k]), 32'(e_idx[k]));
      end
      check("onehot", 32'(bad_oh), 32'd0);
      check("pass_map", 32'(pass_map), 32'(e_pass));
      check("tmo_map", 32'(tmo_map), 32'(e_tmo));
      check("retry_map", 32'(retry_map), 32'(e_retry));
      check("aborted", 32'(aborted), 32'(e_ab));
      check("busy_end", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    eng_mask = '0;
    eng_done = '0;
    eng_pass = '0;
    repeat (2) @(negedge clk);
    check("reset_start", 32'(eng_start), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(sess_done), 32'd0);
    check("reset_maps", 32'({pass_map, tmo_map, retry_map, aborted}), 32'd0);
    reset_n = 1'b1;

    @(negedge clk);
    start = 1'b1; abort = 1'b1; eng_mask = 4'hf;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    check("idle_start_abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_done", 32'(sess_done), 32'd0);

    set_all(5, 1'b1);
    run(4'b1111, -1, 1'b0, -1);
    run(4'b0101, -1, 1'b0, -1);
    m_dly[2][0] = 0; m_dly[2][1] = 0;
    run(4'b1111, -1, 1'b0, -1);
    set_all(5, 1'b1);
    run(4'b1111, 10, 1'b1, -1);
    run(4'b1111, -1, 1'b0, -1);
    run(4'b1111, -1, 1'b0, 21);
    run(4'b1111, -1, 1'b0, -1);
    m_ps[1][0] = 1'b0;
    run(4'b1111, -1, 1'b0, -1);
    set_all(TMO, 1'b1);
    run(4'b1111, -1, 1'b0, -1);
    set_all(TMO + 1, 1'b1);
    run(4'b0011, -1, 1'b0, -1);
    set_all(1, 1'b0);
    run(4'b1111, -1, 1'b0, -1);
    run(4'b0000, -1, 1'b0, -1);

    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < 4; i++)
        for (int a = 0; a < 2; a++) begin
          m_dly[i][a] = ($urandom_range(0, 3) == 0) ?
                        int'($urandom_range(TMO - 2, TMO + 3)) :
                        int'($urandom_range(0, 10));
          m_ps[i][a]  = ($urandom_range(0, 3) != 0);
        end
      run(4'($urandom),
          ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : -1,
          1'($urandom), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
